// File: rtl/op_buf_pkg.sv
// Shared constants, state encoding and count clamping for the output-buffer controller.
package op_buf_pkg;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_COLLECT     = 3'd1,
        ST_DRAIN_FIRST = 3'd2,
        ST_DRAIN       = 3'd3,
        ST_FINISH      = 3'd4
    } state_t;

    // A tile never holds more results than the buffer has entries.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
        return (n > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : n;
    endfunction

endpackage

// File: rtl/op_buf_addr_counter.sv
// Buffer address counter with clear-over-increment priority and a last-entry flag.
module op_buf_addr_counter
    import op_buf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] n_lat,
    output logic [CNT_W-1:0] cnt,
    output logic             at_last
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_last = (cnt == n_lat - CNT_W'(1));

endmodule

// File: rtl/op_buf_controller.sv
// Sequences one tile through the output buffer: collect N results, then drain them
// to the external consumer with a valid/ready handshake.
module op_buf_controller
    import op_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_results,
    input  logic              res_valid,
    output logic              res_ready,
    output logic              store_en,
    output logic [ADDR_W-1:0] store_addr,
    output logic              send_en,
    output logic [ADDR_W-1:0] send_addr,
    output logic              ext_valid,
    input  logic              ext_ready,
    output logic              ext_last,
    output logic              busy,
    output logic              done
);

    state_t           state, next_state;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] n_start;
    logic             n_load;
    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    logic             wr_last, rd_last;
    logic             wr_inc, wr_clr, rd_inc, rd_clr;

    assign n_start = clamp_count(num_results);

    op_buf_addr_counter u_wr_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (wr_inc),
        .clr     (wr_clr),
        .n_lat   (n_lat),
        .cnt     (wr_cnt),
        .at_last (wr_last)
    );

    op_buf_addr_counter u_rd_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (rd_inc),
        .clr     (rd_clr),
        .n_lat   (n_lat),
        .cnt     (rd_cnt),
        .at_last (rd_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            n_lat <= '0;
        end else begin
            state <= next_state;
            if (n_load) begin
                n_lat <= n_start;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        n_load     = 1'b0;
        res_ready  = 1'b0;
        store_en   = 1'b0;
        store_addr = '0;
        send_en    = 1'b0;
        send_addr  = '0;
        ext_valid  = 1'b0;
        ext_last   = 1'b0;
        done       = 1'b0;
        wr_inc     = 1'b0;
        wr_clr     = 1'b0;
        rd_inc     = 1'b0;
        rd_clr     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    n_load     = 1'b1;
                    next_state = (n_start == '0) ? ST_FINISH : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                res_ready  = 1'b1;
                store_en   = res_valid;
                store_addr = wr_cnt[ADDR_W-1:0];
                wr_inc     = res_valid;
                if (res_valid && wr_last) begin
                    wr_clr     = 1'b1;
                    next_state = ST_DRAIN_FIRST;
                end
            end
            ST_DRAIN_FIRST: begin
                // Prefetch word 0 so it is on the buffer output when DRAIN begins.
                send_en    = 1'b1;
                send_addr  = '0;
                next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                ext_valid = 1'b1;
                ext_last  = rd_last;
                if (ext_ready) begin
                    if (rd_last) begin
                        rd_clr     = 1'b1;
                        next_state = ST_FINISH;
                    end else begin
                        send_en   = 1'b1;
                        send_addr = rd_cnt[ADDR_W-1:0] + ADDR_W'(1);
                        rd_inc    = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule
